// File: rtl/oled_pkg.sv
// Shared types and constants for the OLED pixel transmitter: FSM states, default
// panel size, column/row address opcodes and the colour-bar palette.
package oled_pkg;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_CMD  = 2'd1,
    ST_PIX  = 2'd2,
    ST_GAP  = 2'd3
  } oled_state_t;

  localparam int DEFAULT_WIDTH  = 96;
  localparam int DEFAULT_HEIGHT = 64;
  localparam int CMD_BYTES      = 6;

  localparam logic [7:0] CMD_SET_COL = 8'h15;
  localparam logic [7:0] CMD_SET_ROW = 8'h75;

  localparam logic [15:0] COLOR_RED   = 16'hF800;
  localparam logic [15:0] COLOR_GREEN = 16'h07E0;
  localparam logic [15:0] COLOR_BLUE  = 16'h001F;
  localparam logic [15:0] COLOR_WHITE = 16'hFFFF;

  // Address-window preamble: column range 0..last_col, then row range 0..last_row.
  function automatic logic [7:0] cmd_byte(input logic [2:0] idx,
                                          input logic [7:0] last_col,
                                          input logic [7:0] last_row);
    logic [7:0] b;
    case (idx)
      3'd0:    b = CMD_SET_COL;
      3'd1:    b = 8'h00;
      3'd2:    b = last_col;
      3'd3:    b = CMD_SET_ROW;
      3'd4:    b = 8'h00;
      default: b = last_row;
    endcase
    return b;
  endfunction

  function automatic logic [15:0] bar_colour(input int x, input int width);
    logic [15:0] c;
    if (x < width / 4)          c = COLOR_RED;
    else if (x < width / 2)     c = COLOR_GREEN;
    else if (x < 3 * width / 4) c = COLOR_BLUE;
    else                        c = COLOR_WHITE;
    return c;
  endfunction

endpackage

// File: rtl/oled_spi_shift.sv
// 16-bit loadable MSB-first shifter: two CLK cycles per bit (sclk low while sdin
// changes, then high), sclk idles high, and done marks phase 1 of the last bit.
module oled_spi_shift (
  input  logic        clk,
  input  logic        reset,
  input  logic        load,
  input  logic [15:0] word,
  input  logic [4:0]  bits,
  output logic        sclk,
  output logic        sdin,
  output logic        last_rise,
  output logic        done
);

  logic        active;
  logic        phase;
  logic [3:0]  bit_cnt;
  logic [15:0] sreg;

  assign done      = active & phase & (bit_cnt == 4'd0);
  assign last_rise = active & ~phase & (bit_cnt == 4'd0);

  // A load overrides the shift so back-to-back words have no idle cycle.
  always_ff @(posedge clk) begin
    if (reset) begin
      active  <= 1'b0;
      phase   <= 1'b0;
      bit_cnt <= 4'd0;
      sreg    <= 16'd0;
      sclk    <= 1'b1;
      sdin    <= 1'b0;
    end else if (load) begin
      active  <= 1'b1;
      phase   <= 1'b0;
      bit_cnt <= 4'(bits - 5'd1);
      sreg    <= {word[14:0], 1'b0};
      sclk    <= 1'b0;
      sdin    <= word[15];
    end else if (active) begin
      if (!phase) begin
        phase <= 1'b1;
        sclk  <= 1'b1;
      end else if (bit_cnt == 4'd0) begin
        active <= 1'b0;
        phase  <= 1'b0;
        sclk   <= 1'b1;
      end else begin
        phase   <= 1'b0;
        sclk    <= 1'b0;
        sdin    <= sreg[15];
        sreg    <= {sreg[14:0], 1'b0};
        bit_cnt <= bit_cnt - 4'd1;
      end
    end
  end

endmodule

// File: rtl/oled_pixel_tx.sv
// Streams frames to an SPI OLED: 6-byte address preamble, WIDTH*HEIGHT RGB565 pixels,
// then an idle gap. Define OLED_TEST_PATTERN_EN to send colour bars instead of pixel_data.
module oled_pixel_tx
  import oled_pkg::*;
#(
  parameter int WIDTH      = DEFAULT_WIDTH,
  parameter int HEIGHT     = DEFAULT_HEIGHT,
  parameter int GAP_CYCLES = 16
) (
  input  logic        CLK,
  input  logic        reset,
  input  logic [15:0] pixel_data,
  output logic [12:0] pixel_index,
  output logic        sample_pixel,
  output logic        frame_begin,
  output logic        sending_pixels,
  output logic        cs,
  output logic        sclk,
  output logic        sdin,
  output logic        d_cn,
  output logic [1:0]  fsm_state
);

  localparam logic [12:0] LAST_PIX = 13'(WIDTH * HEIGHT - 1);
  localparam logic [7:0]  LAST_COL = 8'(WIDTH - 1);
  localparam logic [7:0]  LAST_ROW = 8'(HEIGHT - 1);
  localparam logic [7:0]  LAST_GAP = 8'(GAP_CYCLES - 1);
  localparam logic [2:0]  LAST_CMD = 3'(CMD_BYTES - 1);

  oled_state_t state;
  logic [2:0]  byte_cnt;
  logic [12:0] pix_cnt;
  logic [7:0]  gap_cnt;
  logic        start_cmd;
  logic        more_pix;
  logic        sh_load;
  logic [15:0] sh_word;
  logic [4:0]  sh_bits;
  logic        word_done;
  logic        last_rise;
  logic [15:0] capture;

  assign fsm_state = state;

`ifdef OLED_TEST_PATTERN_EN
  logic [12:0] x_cnt;

  always_ff @(posedge CLK) begin
    if (reset) begin
      x_cnt <= 13'd0;
    end else if (sample_pixel) begin
      x_cnt <= (x_cnt == 13'(WIDTH - 1) || pixel_index == LAST_PIX) ? 13'd0 : x_cnt + 13'd1;
    end
  end

  assign capture = bar_colour(int'(x_cnt), WIDTH);
`else
  assign capture = pixel_data;
`endif

  always_comb begin
    start_cmd = (state == ST_IDLE) || (state == ST_GAP && gap_cnt == LAST_GAP);
    more_pix  = (state == ST_CMD && byte_cnt == LAST_CMD) ||
                (state == ST_PIX && pix_cnt != LAST_PIX);
    sh_load   = 1'b0;
    sh_word   = 16'd0;
    sh_bits   = 5'd8;
    if (start_cmd) begin
      sh_load = 1'b1;
      sh_word = {cmd_byte(3'd0, LAST_COL, LAST_ROW), 8'h00};
    end else if (word_done && more_pix) begin
      sh_load = 1'b1;
      sh_word = capture;
      sh_bits = 5'd16;
    end else if (word_done && state == ST_CMD) begin
      sh_load = 1'b1;
      sh_word = {cmd_byte(byte_cnt + 3'd1, LAST_COL, LAST_ROW), 8'h00};
    end
  end

  oled_spi_shift u_shift (
    .clk       (CLK),
    .reset     (reset),
    .load      (sh_load),
    .word      (sh_word),
    .bits      (sh_bits),
    .sclk      (sclk),
    .sdin      (sdin),
    .last_rise (last_rise),
    .done      (word_done)
  );

  // sample_pixel is raised one cycle ahead so it coincides with the capturing edge.
  always_ff @(posedge CLK) begin
    if (reset) begin
      state          <= ST_IDLE;
      byte_cnt       <= 3'd0;
      pix_cnt        <= 13'd0;
      gap_cnt        <= 8'd0;
      pixel_index    <= 13'd0;
      cs             <= 1'b1;
      d_cn           <= 1'b0;
      frame_begin    <= 1'b0;
      sample_pixel   <= 1'b0;
      sending_pixels <= 1'b0;
    end else begin
      frame_begin  <= start_cmd;
      sample_pixel <= last_rise && more_pix;
      if (sample_pixel) begin
        pixel_index <= (pixel_index == LAST_PIX) ? 13'd0 : pixel_index + 13'd1;
      end
      case (state)
        ST_IDLE: begin
          state    <= ST_CMD;
          cs       <= 1'b0;
          byte_cnt <= 3'd0;
        end
        ST_CMD: begin
          if (word_done) begin
            if (byte_cnt == LAST_CMD) begin
              state          <= ST_PIX;
              d_cn           <= 1'b1;
              sending_pixels <= 1'b1;
              pix_cnt        <= 13'd0;
            end else begin
              byte_cnt <= byte_cnt + 3'd1;
            end
          end
        end
        ST_PIX: begin
          if (word_done) begin
            if (pix_cnt == LAST_PIX) begin
              state          <= ST_GAP;
              cs             <= 1'b1;
              d_cn           <= 1'b0;
              sending_pixels <= 1'b0;
              gap_cnt        <= 8'd0;
            end else begin
              pix_cnt <= pix_cnt + 13'd1;
            end
          end
        end
        ST_GAP: begin
          if (gap_cnt == LAST_GAP) begin
            state    <= ST_CMD;
            cs       <= 1'b0;
            byte_cnt <= 3'd0;
          end else begin
            gap_cnt <= gap_cnt + 8'd1;
          end
        end
        default: state <= ST_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_oled_pixel_tx.sv
// Bench for oled_pixel_tx on a 16x4 panel: decodes the SPI stream on sclk rising edges
// and checks command bytes, pixel words, frame timing and reset behaviour.
module tb_oled_pixel_tx;
  import oled_pkg::*;

  localparam int W     = 16;
  localparam int H     = 4;
  localparam int G     = 16;
  localparam int N     = W * H;
  localparam int FRAME = 96 + 32 * N + G;

  logic        clk;
  logic        reset;
  logic [15:0] pixel_data;
  logic [12:0] pixel_index;
  logic        sample_pixel;
  logic        frame_begin;
  logic        sending_pixels;
  logic        cs;
  logic        sclk;
  logic        sdin;
  logic        d_cn;
  logic [1:0]  fsm_state;

  oled_pixel_tx #(.WIDTH(W), .HEIGHT(H), .GAP_CYCLES(G)) dut (
    .CLK            (clk),
    .reset          (reset),
    .pixel_data     (pixel_data),
    .pixel_index    (pixel_index),
    .sample_pixel   (sample_pixel),
    .frame_begin    (frame_begin),
    .sending_pixels (sending_pixels),
    .cs             (cs),
    .sclk           (sclk),
    .sdin           (sdin),
    .d_cn           (d_cn),
    .fsm_state      (fsm_state)
  );

  // clock / reset
  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  int errors = 0;
  int checks = 0;

  // stimulus source: 0 = constant colour, 1 = random table indexed by pixel_index one cycle late
  int          mode = 0;
  int          prev_idx = 0;
  logic [15:0] tbl [0:N-1];
  logic [15:0] const_colour;

  task automatic step();
    @(posedge clk);
    #1;
    pixel_data = (mode == 0) ? const_colour : tbl[prev_idx];
    prev_idx   = int'(pixel_index) % N;
  endtask

  task automatic new_table();
    for (int j = 0; j < N; j++) tbl[j] = 16'($urandom_range(0, 65535));
  endtask

  // reference: the word that pixel j of a frame must carry
  function automatic logic [15:0] exp_word(int j);
`ifdef OLED_TEST_PATTERN_EN
    int x;
    x = j % W;
    if (x < W / 4) return 16'hF800;
    if (x < W / 2) return 16'h07E0;
    if (x < 3 * W / 4) return 16'h001F;
    return 16'hFFFF;
`else
    return (mode == 0) ? const_colour : tbl[j];
`endif
  endfunction

  logic [7:0] exp_cmd [0:5];
  initial begin
    exp_cmd[0] = 8'h15; exp_cmd[1] = 8'h00; exp_cmd[2] = 8'(W - 1);
    exp_cmd[3] = 8'h75; exp_cmd[4] = 8'h00; exp_cmd[5] = 8'(H - 1);
  end

  // SPI decoder: bits on sclk rising edges while cs is low, word length chosen by d_cn
  logic [15:0] cmd_q [$];
  logic [15:0] pix_q [$];
  logic [15:0] acc;
  int          nbits = 0;
  logic        prev_sclk = 1'b1;

  always @(negedge clk) begin
    if (reset || cs) begin
      nbits = 0;
    end else if (sclk && !prev_sclk) begin
      acc   = {acc[14:0], sdin};
      nbits = nbits + 1;
      if (!d_cn && nbits == 8) begin
        cmd_q.push_back({8'h00, acc[7:0]});
        nbits = 0;
      end else if (d_cn && nbits == 16) begin
        pix_q.push_back(acc);
        nbits = 0;
      end
    end
    prev_sclk = reset ? 1'b1 : sclk;
  end

  // frame measurements filled by run_frame
  int period, cs_high, samples, min_stable;
  bit wrap_seen;

  task automatic run_frame(output bit ok);
    int n;
    int last_idx;
    int stable;
    ok = 1'b1;
    n  = 0;
    while (!frame_begin && n < FRAME + 50) begin
      step();
      n++;
    end
    if (!frame_begin) begin
      ok = 1'b0;
      return;
    end
    cmd_q.delete();
    pix_q.delete();
    period = 0; cs_high = 0; samples = 0; min_stable = 1000000; wrap_seen = 1'b0;
    stable = 1;
    last_idx = int'(pixel_index);
    do begin
      step();
      period++;
      if (cs) cs_high++;
      if (int'(pixel_index) != last_idx) begin
        if (last_idx == N - 1 && pixel_index == 13'd0) wrap_seen = 1'b1;
        last_idx = int'(pixel_index);
        stable = 1;
      end else begin
        stable++;
      end
      if (sample_pixel) begin
        samples++;
        if (stable < min_stable) min_stable = stable;
      end
    end while (!frame_begin && period < FRAME + 50);
    if (!frame_begin) ok = 1'b0;
  endtask

  task automatic test_reset();
    reset = 1'b1;
    repeat (3) step();
    checks++; if (cs !== 1'b1) begin errors++; $display("FAIL reset_cs got=%b exp=1", cs); end
    checks++; if (sclk !== 1'b1) begin errors++; $display("FAIL reset_sclk got=%b exp=1", sclk); end
    checks++; if (sdin !== 1'b0) begin errors++; $display("FAIL reset_sdin got=%b exp=0", sdin); end
    checks++; if (d_cn !== 1'b0) begin errors++; $display("FAIL reset_d_cn got=%b exp=0", d_cn); end
    checks++; if (frame_begin !== 1'b0) begin errors++; $display("FAIL reset_frame_begin got=%b exp=0", frame_begin); end
    checks++; if (sample_pixel !== 1'b0) begin errors++; $display("FAIL reset_sample_pixel got=%b exp=0", sample_pixel); end
    checks++; if (sending_pixels !== 1'b0) begin errors++; $display("FAIL reset_sending got=%b exp=0", sending_pixels); end
    checks++; if (pixel_index !== 13'd0) begin errors++; $display("FAIL reset_index got=%0d exp=0", pixel_index); end
    checks++; if (fsm_state !== 2'(ST_IDLE)) begin errors++; $display("FAIL reset_state got=%0d exp=%0d", fsm_state, ST_IDLE); end
  endtask

  task automatic test_first_cmd();
    int n;
    cmd_q.delete();
    reset = 1'b0;
    checks++; if (sclk !== 1'b1) begin errors++; $display("FAIL rel_c0_sclk got=%b exp=1", sclk); end
    step();
    checks++; if (frame_begin !== 1'b1) begin errors++; $display("FAIL rel_c1_frame_begin got=%b exp=1", frame_begin); end
    checks++; if (sclk !== 1'b0) begin errors++; $display("FAIL rel_c1_sclk got=%b exp=0", sclk); end
    checks++; if (cs !== 1'b0 || d_cn !== 1'b0) begin errors++; $display("FAIL rel_c1_cs_dcn got=%b%b exp=00", cs, d_cn); end
    step();
    checks++; if (frame_begin !== 1'b0 || sclk !== 1'b1) begin errors++; $display("FAIL rel_c2_fb_sclk got=%b%b exp=01", frame_begin, sclk); end
    n = 0;
    while (cmd_q.size() == 0 && n < 40) begin step(); n++; end
    checks++;
    if (cmd_q.size() == 0 || cmd_q[0] !== 16'h0015) begin
      errors++;
      $display("FAIL rel_first_byte got=%h exp=0015", (cmd_q.size() > 0) ? cmd_q[0] : 16'hxxxx);
    end
  endtask

  task automatic test_const_pixels();
    bit ok;
    mode = 0;
    run_frame(ok);
    checks++; if (!ok) begin errors++; $display("FAIL const_frame_timeout got=0 exp=1"); end
    checks++; if (cmd_q.size() != 6) begin errors++; $display("FAIL const_cmd_count got=%0d exp=6", cmd_q.size()); end
    for (int j = 0; j < 6 && j < cmd_q.size(); j++) begin
      checks++;
      if (cmd_q[j] !== {8'h00, exp_cmd[j]}) begin errors++; $display("FAIL cmd_byte%0d got=%h exp=%h", j, cmd_q[j], exp_cmd[j]); end
    end
    checks++; if (pix_q.size() != N) begin errors++; $display("FAIL const_word_count got=%0d exp=%0d", pix_q.size(), N); end
    for (int j = 0; j < N && j < pix_q.size(); j++) begin
      checks++;
      if (pix_q[j] !== exp_word(j)) begin errors++; $display("FAIL const_word%0d got=%h exp=%h", j, pix_q[j], exp_word(j)); end
    end
  endtask

  task automatic test_indexed_pixels();
    bit ok;
    mode = 1;
    new_table();
    run_frame(ok);
    checks++; if (!ok) begin errors++; $display("FAIL idx_frame_timeout got=0 exp=1"); end
    checks++; if (pix_q.size() != N) begin errors++; $display("FAIL idx_word_count got=%0d exp=%0d", pix_q.size(), N); end
    for (int j = 0; j < N && j < pix_q.size(); j++) begin
      checks++;
      if (pix_q[j] !== exp_word(j)) begin errors++; $display("FAIL idx_word%0d got=%h exp=%h", j, pix_q[j], exp_word(j)); end
    end
  endtask

  task automatic test_frame_timing();
    bit ok;
    run_frame(ok);
    checks++; if (!ok) begin errors++; $display("FAIL timing_frame_timeout got=0 exp=1"); end
    checks++; if (period != FRAME) begin errors++; $display("FAIL frame_period got=%0d exp=%0d", period, FRAME); end
    checks++; if (cs_high != G) begin errors++; $display("FAIL gap_cs_high got=%0d exp=%0d", cs_high, G); end
    checks++; if (!wrap_seen) begin errors++; $display("FAIL index_wrap got=0 exp=1"); end
    checks++; if (samples != N) begin errors++; $display("FAIL sample_count got=%0d exp=%0d", samples, N); end
    checks++; if (min_stable < 30) begin errors++; $display("FAIL index_stable got=%0d exp>=30", min_stable); end
  endtask

  task automatic test_back_to_back();
    bit ok;
    for (int f = 0; f < 2; f++) begin
      new_table();
      run_frame(ok);
      checks++; if (!ok) begin errors++; $display("FAIL b2b%0d_timeout got=0 exp=1", f); end
      checks++; if (pix_q.size() != N) begin errors++; $display("FAIL b2b%0d_count got=%0d exp=%0d", f, pix_q.size(), N); end
      for (int j = 0; j < N && j < pix_q.size(); j++) begin
        checks++;
        if (pix_q[j] !== exp_word(j)) begin errors++; $display("FAIL b2b%0d_word%0d got=%h exp=%h", f, j, pix_q[j], exp_word(j)); end
      end
    end
  endtask

  task automatic test_mid_reset();
    int n;
    int seen;
    n = 0;
    while (!frame_begin && n < FRAME + 50) begin step(); n++; end
    n = 0;
    seen = 0;
    while (seen < N / 2 && n < FRAME) begin
      step();
      n++;
      if (sample_pixel) seen++;
    end
    checks++; if (seen != N / 2) begin errors++; $display("FAIL midrst_reach got=%0d exp=%0d", seen, N / 2); end
    reset = 1'b1;
    step();
    checks++; if (cs !== 1'b1) begin errors++; $display("FAIL midrst_cs got=%b exp=1", cs); end
    checks++; if (pixel_index !== 13'd0) begin errors++; $display("FAIL midrst_index got=%0d exp=0", pixel_index); end
    checks++; if (sclk !== 1'b1 || sending_pixels !== 1'b0) begin errors++; $display("FAIL midrst_sclk_send got=%b%b exp=10", sclk, sending_pixels); end
    reset = 1'b0;
    cmd_q.delete();
    step();
    checks++; if (frame_begin !== 1'b1) begin errors++; $display("FAIL midrst_frame_begin got=%b exp=1", frame_begin); end
    n = 0;
    while (cmd_q.size() == 0 && n < 40) begin step(); n++; end
    checks++;
    if (cmd_q.size() == 0 || cmd_q[0] !== 16'h0015) begin
      errors++;
      $display("FAIL midrst_first_byte got=%h exp=0015", (cmd_q.size() > 0) ? cmd_q[0] : 16'hxxxx);
    end
  endtask

  initial begin
    reset = 1'b1;
`ifdef OLED_TEST_PATTERN_EN
    const_colour = 16'h0000;
`else
    const_colour = 16'hA5C3;
`endif
    pixel_data = const_colour;
    new_table();
    test_reset();
    test_first_cmd();
    test_const_pixels();
    test_indexed_pixels();
    test_frame_timing();
    test_back_to_back();
    test_mid_reset();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/oled_pixel_tx.md
OLED_PIXEL_TX -- requirements
Module: oled_pixel_tx

Interface
REQ-001 SHALL have parameter WIDTH, default 96: pixel columns per frame.
REQ-002 SHALL have parameter HEIGHT, default 64: pixel rows per frame.
REQ-003 SHALL have parameter GAP_CYCLES, default 16: idle CLK cycles between frames, range 1..255.
REQ-004 SHALL have port CLK, input, 1 bit: the single clock; all logic on its rising edge.
REQ-005 SHALL have port reset, input, 1 bit: synchronous, active-high reset.
REQ-006 SHALL have port pixel_data, input, 16 bits: RGB565 colour for the pixel at pixel_index.
REQ-007 SHALL have port pixel_index, output, 13 bits: raster index (y*WIDTH+x) of the next pixel to load.
REQ-008 SHALL have port sample_pixel, output, 1 bit: one-cycle pulse on the cycle pixel_data is captured.
REQ-009 SHALL have ports frame_begin and sending_pixels, outputs, 1 bit each: frame-start pulse and pixel-phase flag.
REQ-010 SHALL have ports cs, sclk, sdin and d_cn, outputs, 1 bit each: SPI chip select (low active), clock, data and data/command select.

Function
REQ-011 SHALL implement FSM states IDLE, CMD, PIX and GAP.
- IDLE -> CMD on the first cycle after reset release.
- CMD -> PIX after 6 bytes.
- PIX -> GAP after WIDTH*HEIGHT pixels.
- GAP -> CMD after GAP_CYCLES cycles.
REQ-012 SHALL pulse frame_begin high for exactly one cycle on each entry to CMD.
REQ-013 SHALL send in CMD, with d_cn=0, bytes 0x15, 0x00, WIDTH-1, 0x75, 0x00, HEIGHT-1 in that order.
REQ-014 SHALL send each bit over 2 CLK cycles.
- Phase 0: sclk=0 and sdin updated.
- Phase 1: sclk=1 and sdin held.
- MSB first.
- sclk SHALL idle high.
REQ-015 SHALL hold cs=0 continuously from the first CMD bit to the last PIX bit, and cs=1 in IDLE and GAP.
REQ-016 SHALL in PIX hold d_cn=1 and sending_pixels=1, and send each pixel as 16 bits (32 CLK cycles) MSB first.
REQ-017 SHALL capture pixel_data into the shift register, with sample_pixel=1, on phase 1 of the last bit of the preceding word (last CMD byte for pixel 0).
REQ-018 SHALL increment pixel_index on the cycle after each sample_pixel.
- pixel_index SHALL be stable for at least 30 cycles before each capture.
REQ-019 SHALL hold pixel_index at 0 from reset and during CMD, and wrap it to 0 after index WIDTH*HEIGHT-1 is captured.
REQ-020 SHALL make each frame occupy exactly 96 + 32*WIDTH*HEIGHT + GAP_CYCLES cycles (196720 at defaults), frame_begin to frame_begin.
REQ-021 SHALL ignore pixel_data changes except on sample_pixel cycles.

Reset
REQ-022 SHALL on reset set state=IDLE, cs=1, sclk=1, sdin=0, d_cn=0, frame_begin=0, sample_pixel=0, sending_pixels=0, pixel_index=0, and clear all counters.
REQ-023 SHALL on reset asserted mid-frame abort within the same cycle, with cs high on the next cycle, and restart a full frame from CMD.

Configuration
REQ-024 SHALL, with OLED_TEST_PATTERN_EN defined, capture instead of pixel_data a colour-bar value: x<WIDTH/4 -> 0xF800, <WIDTH/2 -> 0x07E0, <3*WIDTH/4 -> 0x001F, else 0xFFFF.
- All timing and ports SHALL be unchanged.
REQ-025 SHALL, without OLED_TEST_PATTERN_EN, use pixel_data as specified and contain no pattern logic.

Structure
REQ-026 SHALL place the state enum, the default WIDTH/HEIGHT, the command opcodes 0x15/0x75 and the colour constants in shared package oled_pkg.
REQ-027 SHALL instantiate one sub-module, oled_spi_shift: a 16-bit loadable MSB-first shifter generating sclk/sdin phases and a word-done strobe.

Verification
REQ-028 SHALL cover reset release: sclk toggles on the 2nd cycle, frame_begin=1 on cycle 1, and sdin carries 0x15 bits 0,0,0,1,0,1,0,1 on sclk rising edges with d_cn=0.
REQ-029 SHALL cover a constant pixel_data=0xA5C3: every PIX word decoded on sclk rising edges equals 0xA5C3, with 6144 words per frame.
REQ-030 SHALL cover a generator returning pixel_data=pixel_index registered 1 cycle late: decoded words equal 0..6143 in order.
REQ-031 SHALL cover a frame_begin period of 196720 cycles, cs high for exactly 16 cycles between frames, and the pixel_index wrap 6143 -> 0.
REQ-032 SHALL cover reset asserted at pixel 3000: next cycle cs=1 and pixel_index=0, then a fresh frame_begin and 0x15 command.
REQ-033 SHALL cover OLED_TEST_PATTERN_EN with pixel_data=0x0000: row 0 decodes as 24 words each of F800, 07E0, 001F and FFFF.
